fifo_fir_mac: RTL
=================

FIFO_FIR_MAC -- requirements
Module: fifo_fir_mac

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, sample width (signed, two's complement).
REQ-002 The block SHALL have parameter TAPS, default 4, number of filter taps (2..16).
REQ-003 The block SHALL have parameter COEF_WIDTH, default 16, coefficient width (signed).
REQ-004 The block SHALL derive ACC_WIDTH = WIDTH + COEF_WIDTH + clog2(TAPS).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 The block SHALL have port fifo_empty, input, 1, upstream FIFO holds no data.
REQ-008 The block SHALL have port data_in, input, WIDTH, upstream FIFO data_out; valid whenever fifo_empty=0 (first-word-fall-through).
REQ-009 The block SHALL have port r_ready, output, 1, pop request to the upstream FIFO.
REQ-010 The block SHALL have port coef, input, TAPS*COEF_WIDTH, coefficients; coef[k] occupies bits [k*COEF_WIDTH +: COEF_WIDTH].
REQ-011 The block SHALL have port y_data, output, ACC_WIDTH, filter result.
REQ-012 The block SHALL have port y_valid, output, 1, y_data holds a result.
REQ-013 The block SHALL have port y_ready, input, 1, downstream accepts y_data.

Function
REQ-014 A pop SHALL occur on a rising edge where r_ready=1 and fifo_empty=0; no other condition consumes a sample.
REQ-015 The FSM SHALL have states IDLE, MAC, OUT; r_ready SHALL be 1 only in IDLE and 0 during reset.
REQ-016 In IDLE, on a pop: x[k] <= x[k-1] for k=1..TAPS-1, x[0] <= data_in, acc <= 0, tap index <= 0, go to MAC; with fifo_empty=1, stay in IDLE.
REQ-017 MAC SHALL last exactly TAPS cycles: each cycle acc <= acc + x[i]*coef[i] (signed, full precision), i = 0..TAPS-1; go to OUT after i=TAPS-1.
REQ-018 coef SHALL be sampled during the MAC cycle that uses it; a change mid-MAC affects only the taps not yet accumulated.
REQ-019 OUT SHALL drive y_valid=1 and y_data=acc, with both held stable until y_ready=1; at that edge, return to IDLE.
REQ-020 Latency SHALL be: pop at edge N, y_valid high after edge N+TAPS; with y_ready=1, peak throughput is one sample per TAPS+2 cycles.
REQ-021 y_data SHALL be exactly y[n] = sum over k of coef[k]*x[n-k], with no truncation or saturation; ACC_WIDTH guarantees no overflow.
REQ-022 fifo_empty toggling while in MAC or OUT SHALL have no effect.
REQ-023 A y_ready=1 outside OUT SHALL be ignored.

Reset
REQ-024 On any edge with reset=1: state <= IDLE, x[*] <= 0, acc <= 0, tap index <= 0, y_valid <= 0, y_data <= 0.
REQ-025 Reset during MAC or OUT SHALL discard the partial or pending result; no y_valid pulse follows.
REQ-026 After reset, the first result SHALL treat all earlier history samples as 0.

Structure
REQ-027 Package fifo_fir_pkg SHALL hold the state enum (IDLE/MAC/OUT) and the ACC_WIDTH derivation function.
REQ-028 The signed multiply-accumulate datapath SHALL be one sub-module, fir_mac_unit (clear, enable, x, c -> acc); the FSM and delay line stay in fifo_fir_mac.

Verification (WIDTH=32, TAPS=4, COEF_WIDTH=16, coef = {1,2,3,4} for k=0..3, upstream fifo DEPTH=3)
REQ-029 Idle with empty FIFO: reset, no writes for 20 cycles -> r_ready=1 throughout, no pop, y_valid=0.
REQ-030 Impulse: push 1,0,0,0 with y_ready=1 -> y_data sequence 1,2,3,4, each y_valid exactly 1 cycle, first result TAPS+1 cycles after its pop.
REQ-031 Step plus sign: push 1,1,1,1,1 -> 1,3,6,10,10; then push 32'hFFFFFFFF after reset -> y_data = -1 sign-extended to ACC_WIDTH.
REQ-032 Backpressure: y_ready=0 for 10 cycles during OUT while 3 samples are written -> y_data stable, r_ready=0, fifo_full=1; release y_ready -> remaining results follow in order with none lost.
REQ-033 Reset mid-MAC: assert reset at tap 2 of a sample -> no y_valid; the next push of 5 yields y_data=5.
REQ-034 Bench model: a reference FIR fed by the same stream, with auto-compare of every accepted y_data over 1000 random samples, random fifo writes and random y_ready.

Source files
------------

// File: rtl/fifo_fir_pkg.sv
// Shared definitions for the FIFO-fed FIR multiply-accumulate filter:
// controller state encoding and accumulator sizing.
package fifo_fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Full-precision sum of `taps` products of width x coef_width bits.
    function automatic int acc_width(input int width, input int coef_width, input int taps);
        return width + coef_width + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate slice: acc <= 0 on clear, acc += x*c on enable.
module fir_mac_unit #(
    parameter int WIDTH      = 32,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = 50
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         enable,
    input  logic signed [WIDTH-1:0]      x,
    input  logic signed [COEF_WIDTH-1:0] c,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [WIDTH+COEF_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]        prod_ext;

    // Both operands are signed, so the product is a full-width two's complement result.
    assign prod     = x * c;
    assign prod_ext = ACC_WIDTH'(prod);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/fifo_fir_mac.sv
// FIR filter pulling samples from a first-word-fall-through FIFO; one
// sample is popped, TAPS products are accumulated serially, then the result is held.
module fifo_fir_mac
    import fifo_fir_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int TAPS       = 4,
    parameter  int COEF_WIDTH = 16,
    localparam int ACC_WIDTH  = acc_width(WIDTH, COEF_WIDTH, TAPS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fifo_empty,
    input  logic [WIDTH-1:0]             data_in,
    output logic                         r_ready,
    input  logic [TAPS*COEF_WIDTH-1:0]   coef,
    output logic signed [ACC_WIDTH-1:0]  y_data,
    output logic                         y_valid,
    input  logic                         y_ready
);

    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);

    state_t state, state_n;

    logic signed [WIDTH-1:0]      x_q [TAPS];
    logic [IDX_W-1:0]             tap_idx;
    logic                         pop;
    logic                         mac_en;
    logic                         mac_clear;
    logic signed [WIDTH-1:0]      x_sel;
    logic signed [COEF_WIDTH-1:0] c_sel;
    logic signed [ACC_WIDTH-1:0]  acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement leaves a latch behind.
    always_comb begin
        state_n = state;
        r_ready = 1'b0;
        mac_en  = 1'b0;
        case (state)
            IDLE: begin
                r_ready = !reset;
                if (!fifo_empty && !reset) begin
                    state_n = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (tap_idx == LAST_TAP) begin
                    state_n = OUT;
                end
            end
            OUT: begin
                if (y_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign pop       = r_ready && !fifo_empty;
    assign mac_clear = reset || pop;

    // NOTE: the delay line is a small register array, not a RAM, so it is
    // cleared on reset; the first result after reset then sees zero history.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
            tap_idx <= '0;
        end else if (pop) begin
            for (int k = 1; k < TAPS; k++) begin
                x_q[k] <= x_q[k-1];
            end
            x_q[0]  <= data_in;
            tap_idx <= '0;
        end else if (mac_en) begin
            tap_idx <= (tap_idx == LAST_TAP) ? '0 : tap_idx + 1'b1;
        end
    end

    // Coefficients are read live, so a mid-run change only affects taps not yet summed.
    always_comb begin
        x_sel = x_q[tap_idx];
        c_sel = coef[int'(tap_idx)*COEF_WIDTH +: COEF_WIDTH];
    end

    fir_mac_unit #(
        .WIDTH      (WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk    (clk),
        .clear  (mac_clear),
        .enable (mac_en),
        .x      (x_sel),
        .c      (c_sel),
        .acc    (acc)
    );

    // The accumulator is frozen outside MAC, so it doubles as the held result.
    assign y_valid = (state == OUT);
    assign y_data  = acc;

endmodule
